// File: rtl/contador_pc_pkg.sv
// Shared defaults for the program-counter register block.
// Consumed by contador_pc and its optional perf counter (CONTADOR_PC_PERF_EN).
package contador_pc_pkg;

   localparam int XLEN_DEF = 32;
   localparam int RESET_VECTOR_DEF = 0;
   localparam int PC_INCR = 4;
   localparam int CNT_W_DEF = 64;

   // Low PC bits that must read as zero for a 4-byte aligned fetch address.
   localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage : contador_pc_pkg

// File: rtl/contador_pc_perf.sv
// Wrapping update counter: counts every non-reset clock edge of the PC register.
// Instantiated by contador_pc only when CONTADOR_PC_PERF_EN is defined.
module contador_pc_perf
   import contador_pc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule : contador_pc_perf

// File: rtl/contador_pc.sv
// Program counter register: aligned load every edge, PC+4, previous PC, misalignment flag.
// Optional update counter port upd_count when CONTADOR_PC_PERF_EN is defined.
module contador_pc
   import contador_pc_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter int              CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  PCNext,
   output logic [XLEN-1:0]  PC,
   output logic [XLEN-1:0]  PCPlus4,
   output logic [XLEN-1:0]  PCPrev,
   output logic             misaligned
`ifdef CONTADOR_PC_PERF_EN
   ,
   output logic [CNT_W-1:0] upd_count
`endif
);

   // Elaboration-time guard: the aligned slice below needs at least 3 PC bits.
   if (XLEN < 3 || CNT_W < 1) begin : g_bad_param
      $error("contador_pc: XLEN must be >= 3 and CNT_W >= 1");
   end

   logic [XLEN-1:0] pc_aligned;
   logic [XLEN-1:0] reset_pc;

   assign pc_aligned = {PCNext[XLEN-1:2], PCNext[1:0] & ~PC_ALIGN_MASK};
   assign reset_pc   = {RESET_VECTOR[XLEN-1:2], RESET_VECTOR[1:0] & ~PC_ALIGN_MASK};

   always_ff @(posedge clk) begin
      if (reset) begin
         PC         <= reset_pc;
         PCPrev     <= RESET_VECTOR;
         misaligned <= 1'b0;
      end else begin
         PC         <= pc_aligned;
         PCPrev     <= PC;
         misaligned <= |(PCNext[1:0] & PC_ALIGN_MASK);
      end
   end

   // Wraps modulo 2^XLEN by construction; carry out is dropped.
   assign PCPlus4 = PC + XLEN'(PC_INCR);

`ifdef CONTADOR_PC_PERF_EN
   contador_pc_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk   (clk),
      .reset (reset),
      .count (upd_count)
   );
`endif

endmodule : contador_pc

// File: tb/tb_contador_pc.sv
// Self-checking bench for contador_pc: vector table plus hand-written reset sequences.
// Covers the upd_count port as well when CONTADOR_PC_PERF_EN is defined.
module tb_contador_pc;

   localparam int XLEN = 32;
   localparam int CNT_W = 64;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_prev;
   logic            mis;

   // Second instance with an unaligned reset vector.
   logic [XLEN-1:0] pc_b;
   logic [XLEN-1:0] pc_plus4_b;
   logic [XLEN-1:0] pc_prev_b;
   logic            mis_b;

`ifdef CONTADOR_PC_PERF_EN
   logic [CNT_W-1:0] upd_count;
   logic [CNT_W-1:0] upd_count_b;
`endif

   contador_pc #(
      .XLEN         (XLEN),
      .RESET_VECTOR (32'h0000_0000),
      .CNT_W        (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .PCNext     (pc_next),
      .PC         (pc),
      .PCPlus4    (pc_plus4),
      .PCPrev     (pc_prev),
      .misaligned (mis)
`ifdef CONTADOR_PC_PERF_EN
      ,
      .upd_count  (upd_count)
`endif
   );

   contador_pc #(
      .XLEN         (XLEN),
      .RESET_VECTOR (32'h0000_1003),
      .CNT_W        (CNT_W)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .PCNext     (pc_next),
      .PC         (pc_b),
      .PCPlus4    (pc_plus4_b),
      .PCPrev     (pc_prev_b),
      .misaligned (mis_b)
`ifdef CONTADOR_PC_PERF_EN
      ,
      .upd_count  (upd_count_b)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic            rst;
      logic [XLEN-1:0] nxt;
      logic [XLEN-1:0] e_pc;
      logic [XLEN-1:0] e_plus4;
      logic [XLEN-1:0] e_prev;
      logic            e_mis;
   } vec_t;

   vec_t vecs[14];

   task automatic step(input logic r, input logic [XLEN-1:0] n);
      @(negedge clk);
      reset   = r;
      pc_next = n;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      pc_next = 32'h0000_0055;

      //            rst   PCNext         PC             PCPlus4        PCPrev         mis
      vecs[0]  = '{1'b1, 32'h0000_0055, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0000_0004, 32'h0000_0008, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 32'h0000_0004, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0000_000C, 32'h0000_0010, 32'h0000_0008, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0014, 32'h0000_000C, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0010, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100, 1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0104, 32'h0000_0104, 32'h0000_0108, 32'h0000_0100, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0104, 32'h0000_0104, 32'h0000_0108, 32'h0000_0104, 1'b0};
      vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0104, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0};
      vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 32'h0000_0041, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0020, 32'h0000_0020, 32'h0000_0024, 32'h0000_0000, 1'b0};

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].rst, vecs[i].nxt);
         chk($sformatf("v%0d_pc", i),    64'(pc),       64'(vecs[i].e_pc));
         chk($sformatf("v%0d_plus4", i), 64'(pc_plus4), 64'(vecs[i].e_plus4));
         chk($sformatf("v%0d_prev", i),  64'(pc_prev),  64'(vecs[i].e_prev));
         chk($sformatf("v%0d_mis", i),   64'(mis),      64'(vecs[i].e_mis));
      end

      // Mid-run reset at PC=0x20; the unaligned reset vector gets its low bits cleared.
      step(1'b1, 32'h0000_0024);
      chk("midrst_pc", 64'(pc), 64'h0);
      chk("midrst_mis", 64'(mis), 64'h0);
      chk("rvec_pc", 64'(pc_b), 64'h0000_1000);
      chk("rvec_plus4", 64'(pc_plus4_b), 64'h0000_1004);
      chk("rvec_prev", 64'(pc_prev_b), 64'h0000_1003);
`ifdef CONTADOR_PC_PERF_EN
      chk("midrst_cnt", 64'(upd_count), 64'd0);
`endif

      step(1'b0, 32'h0000_0004);
      chk("post_pc1", 64'(pc), 64'h4);
      chk("post_prev_b", 64'(pc_prev_b), 64'h0000_1000);
      step(1'b0, 32'h0000_0008);
      chk("post_pc2", 64'(pc), 64'h8);
      step(1'b0, 32'h0000_000E);
      chk("post_pc3", 64'(pc), 64'hC);
      chk("post_mis3", 64'(mis), 64'h1);
`ifdef CONTADOR_PC_PERF_EN
      chk("post_cnt3", 64'(upd_count), 64'd3);
      chk("post_cnt3_b", 64'(upd_count_b), 64'd3);
`endif
      step(1'b1, 32'h0000_0010);
      chk("rst2_pc", 64'(pc), 64'h0);
`ifdef CONTADOR_PC_PERF_EN
      chk("rst2_cnt", 64'(upd_count), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_contador_pc

// File: doc/contador_pc.md
CONTADOR_PC -- requirements
Module: contador_pc

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning program-counter width in bits.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 SHALL provide parameter CNT_W, default 64, meaning the width of the optional update counter.
REQ-004 SHALL provide port clk, input, 1 bit, the single rising-edge clock.
REQ-005 SHALL provide port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL provide port PCNext, input, XLEN bits, the next-PC value to load.
REQ-007 SHALL provide port PC, output, XLEN bits, the registered current PC.
REQ-008 SHALL provide port PCPlus4, output, XLEN bits, combinational PC + 4.
REQ-009 SHALL provide port PCPrev, output, XLEN bits, the registered PC value from before the last load.
REQ-010 SHALL provide port misaligned, output, 1 bit, registered flag for a misaligned last load.
REQ-011 SHALL provide port upd_count, output, CNT_W bits, present only when CONTADOR_PC_PERF_EN is defined.
REQ-012 SHALL require only clk, reset and PCNext to be connected; all extra ports are outputs and may be left open.

Function
REQ-013 SHALL load PC <= {PCNext[XLEN-1:2], 2'b00} on every rising clk edge when reset is low; there is no enable or stall.
REQ-014 SHALL have a load latency of exactly one cycle: a PCNext value sampled at edge N appears on PC after edge N.
REQ-015 SHALL set misaligned <= (PCNext[1:0] != 2'b00) on the same edge as the load, holding the value until the next edge.
REQ-016 SHALL compute PCPlus4 = PC + 4 modulo 2^XLEN, so 32'hFFFF_FFFC + 4 gives 32'h0000_0000 with no carry out.
REQ-017 SHALL set PCPrev <= PC on each non-reset edge.
REQ-018 SHALL produce PC values that are always 4-byte aligned, including when PCNext wraps from 32'hFFFF_FFFC to 0.
REQ-019 SHALL load an unchanged PCNext again without side effects, with PC holding its value.

Reset
REQ-020 SHALL sample reset only on the rising clk edge, with no asynchronous path.
REQ-021 SHALL, when reset is high at an edge, set PC <= RESET_VECTOR with bits [1:0] forced to 0, PCPrev <= RESET_VECTOR, misaligned <= 0 and upd_count <= 0.
REQ-022 SHALL give reset priority over PCNext, ignoring PCNext on reset edges.
REQ-023 SHALL abort any update in progress when reset is asserted mid-run, with PC equal to RESET_VECTOR after that edge.
REQ-024 SHALL make the first load after reset deassertion occur at the first edge where reset is low.
REQ-025 SHALL keep all outputs X until the first reset edge, with no initial blocks used for function.

Configuration
REQ-026 SHALL, when CONTADOR_PC_PERF_EN is defined, add port upd_count that increments by 1, wrapping at 2^CNT_W, on every non-reset edge.
REQ-027 SHALL, when CONTADOR_PC_PERF_EN is undefined, omit both the upd_count port and its register, leaving all other behaviour identical.

Structure
REQ-028 SHALL place the defaults XLEN_DEF=32, RESET_VECTOR_DEF=0, PC_INCR=4 and PC_ALIGN_MASK in shared package contador_pc_pkg.
REQ-029 SHALL split out a natural sub-module, contador_pc_perf, holding the wrapping counter, instantiated only under CONTADOR_PC_PERF_EN.
REQ-030 SHALL be implemented as a flat register block with no FSM.

Verification
REQ-031 SHALL cover reset: 20 ns clock, reset=1 for the first edge -> PC=0, PCPlus4=4, misaligned=0.
REQ-032 SHALL cover sequential fetch: reset released, bench drives PCNext=PC+4 every cycle -> PC=4, 8, 12, 16 on successive edges.
REQ-033 SHALL cover a branch: PCNext=32'h0000_0100 for one edge -> PC=32'h100, PCPrev equals the old PC.
REQ-034 SHALL cover misalignment: PCNext=32'h0000_0102 -> PC=32'h100, misaligned=1 for one cycle, then PCNext=32'h104 gives misaligned=0.
REQ-035 SHALL cover wrap: PCNext=32'hFFFF_FFFC -> PC=32'hFFFF_FFFC, PCPlus4=0, next load of 0 gives PC=0.
REQ-036 SHALL cover mid-run reset with CONTADOR_PC_PERF_EN defined: reset=1 at PC=32'h20 -> PC=0, upd_count=0, then 3 edges give upd_count=3.
